seq_checker: RTL and testbench

Receive-side companion to the mod-5 sequence counter: samples a 3-bit code stream that must follow 0 → 1 → 3 → 7 → 2 → 0 and decodes each code to its position index (0..4). It acquires lock after a configurable run of in-order codes and flags out-of-order codes with a per-sample error pulse and a saturating error count. It drops lock after repeated misses and re-hunts. It sits on the far end of any link carrying counter output and checks counter integrity.

---
 rtl/seq_checker_pkg.sv | 53 +++++
 rtl/seq_checker_if.sv | 37 +++
 rtl/seq_code_decoder.sv | 21 ++
 rtl/seq_checker.sv | 154 +++++++++++++++
 tb/tb_seq_checker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_checker_pkg.sv
// Shared types and code helpers for the mod-5 sequence checker.
// The legal code ring is 0 -> 1 -> 3 -> 7 -> 2 -> 0; codes 4, 5 and 6 are illegal.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] CODE_P0 = 3'd0;
    localparam logic [2:0] CODE_P1 = 3'd1;
    localparam logic [2:0] CODE_P2 = 3'd3;
    localparam logic [2:0] CODE_P3 = 3'd7;
    localparam logic [2:0] CODE_P4 = 3'd2;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } dec_t;

    // Illegal codes have no successor; they map to CODE_P0 so callers get a defined value.
    function automatic logic [2:0] succ(input logic [2:0] code);
        case (code)
            CODE_P0: return CODE_P1;
            CODE_P1: return CODE_P2;
            CODE_P2: return CODE_P3;
            CODE_P3: return CODE_P4;
            CODE_P4: return CODE_P0;
            default: return CODE_P0;
        endcase
    endfunction

    function automatic dec_t decode(input logic [2:0] code);
        dec_t d;
        d.legal = 1'b1;
        case (code)
            CODE_P0: d.idx = 3'd0;
            CODE_P1: d.idx = 3'd1;
            CODE_P2: d.idx = 3'd2;
            CODE_P3: d.idx = 3'd3;
            CODE_P4: d.idx = 3'd4;
            default: begin
                d.legal = 1'b0;
                d.idx   = 3'd0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Sample stream and status bundle between a code source and seq_checker.
// The illegal pulse exists only when SEQ_CHK_ILLEGAL_DETECT_EN is defined.
interface seq_checker_if;

    logic [2:0] q_in;
    logic       q_valid;
    logic       clr_cnt;
    logic [2:0] idx;
    logic [2:0] expected;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
`ifdef SEQ_CHK_ILLEGAL_DETECT_EN
    logic       illegal;

    modport master (
        output q_in, q_valid, clr_cnt,
        input  idx, expected, locked, err, err_cnt, illegal
    );

    modport slave (
        input  q_in, q_valid, clr_cnt,
        output idx, expected, locked, err, err_cnt, illegal
    );
`else
    modport master (
        output q_in, q_valid, clr_cnt,
        input  idx, expected, locked, err, err_cnt
    );

    modport slave (
        input  q_in, q_valid, clr_cnt,
        output idx, expected, locked, err, err_cnt
    );
`endif

endinterface

// File: rtl/seq_code_decoder.sv
// Combinational decode of one sampled code into legality, ring position and successor.
module seq_code_decoder
    import seq_chk_pkg::*;
(
    input  logic [2:0] code,
    output logic       legal,
    output logic [2:0] idx,
    output logic [2:0] code_succ
);

    dec_t dec;

    always_comb begin
        dec = decode(code);
    end

    assign legal     = dec.legal;
    assign idx       = dec.idx;
    assign code_succ = succ(code);

endmodule

// File: rtl/seq_checker.sv
// Receive-side integrity checker for the mod-5 counter code stream: hunt, verify, lock, flywheel.
// Optional feature macro: SEQ_CHK_ILLEGAL_DETECT_EN adds the illegal-code pulse output.
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    seq_checker_if.slave  bus
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_N = 4'(ERR_LIMIT);

    state_t     state;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;
    logic [2:0] idx_r;
    logic [2:0] expected_r;
    logic       locked_r;
    logic       err_r;
    logic [7:0] err_cnt_r;

    logic       dec_legal;
    logic [2:0] dec_idx;
    logic [2:0] dec_succ;
    logic       match;
    logic       lock_miss;
    logic [3:0] match_nxt;
    logic [3:0] miss_nxt;

    seq_code_decoder u_dec (
        .code      (bus.q_in),
        .legal     (dec_legal),
        .idx       (dec_idx),
        .code_succ (dec_succ)
    );

    assign match     = (bus.q_in == expected_r);
    assign lock_miss = bus.q_valid && (state == LOCKED) && !match;
    assign match_nxt = match_cnt + 4'd1;
    assign miss_nxt  = miss_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            match_cnt  <= 4'd0;
            miss_cnt   <= 4'd0;
            idx_r      <= 3'd0;
            expected_r <= CODE_P0;
            locked_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (bus.q_valid) begin
                if (dec_legal) begin
                    idx_r <= dec_idx;
                end
                case (state)
                    HUNT: begin
                        if (dec_legal) begin
                            expected_r <= dec_succ;
                            match_cnt  <= 4'd1;
                            if (LOCK_N == 4'd1) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        // expected is always a legal code here, so a match implies legality
                        if (match) begin
                            match_cnt  <= match_nxt;
                            expected_r <= dec_succ;
                            if (match_nxt == LOCK_N) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                            end
                        end else if (dec_legal) begin
                            match_cnt  <= 4'd1;
                            expected_r <= dec_succ;
                        end else begin
                            state      <= HUNT;
                            match_cnt  <= 4'd0;
                            expected_r <= CODE_P0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_cnt   <= 4'd0;
                            expected_r <= dec_succ;
                        end else begin
                            err_r <= 1'b1;
                            if (miss_nxt == MISS_N) begin
                                state      <= HUNT;
                                locked_r   <= 1'b0;
                                expected_r <= CODE_P0;
                                miss_cnt   <= 4'd0;
                                match_cnt  <= 4'd0;
                            end else begin
                                // flywheel: advance along the ring as if the sample had been right
                                miss_cnt   <= miss_nxt;
                                expected_r <= succ(expected_r);
                            end
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        match_cnt  <= 4'd0;
                        miss_cnt   <= 4'd0;
                        expected_r <= CODE_P0;
                        locked_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear in the same cycle as a counted miss takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_r <= 8'd0;
        end else if (bus.clr_cnt) begin
            err_cnt_r <= 8'd0;
        end else if (lock_miss && (err_cnt_r != ERR_CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

`ifdef SEQ_CHK_ILLEGAL_DETECT_EN
    logic illegal_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= bus.q_valid && !dec_legal;
        end
    end

    assign bus.illegal = illegal_r;
`endif

    assign bus.idx      = idx_r;
    assign bus.expected = expected_r;
    assign bus.locked   = locked_r;
    assign bus.err      = err_r;
    assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: directed vector table, multi-cycle corner sequences and a random run
// compared against a ring-position reference model.
module tb_seq_checker;

    localparam int LC = 3;
    localparam int EL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_checker_if bus ();

    seq_checker #(.LOCK_COUNT(LC), .ERR_LIMIT(EL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the ring as an ordered list of codes; state kept as plain integers.
    int ring[5] = '{0, 1, 3, 7, 2};
    int m_state;   // 0 hunt, 1 verify, 2 locked
    int m_exp, m_run, m_miss, m_idx, m_err, m_cnt, m_ill;

    function automatic int pos_of(input int code);
        for (int i = 0; i < 5; i++) if (ring[i] == code) return i;
        return -1;
    endfunction

    function automatic int next_code(input int code);
        return ring[(pos_of(code) + 1) % 5];
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_run = 0; m_miss = 0;
        m_idx = 0; m_err = 0; m_cnt = 0; m_ill = 0;
    endtask

    task automatic model_step(input bit v, input int q, input bit c);
        int p;
        m_err = 0;
        m_ill = 0;
        if (v) begin
            p = pos_of(q);
            if (p >= 0) m_idx = p;
            m_ill = (p < 0);
            if (m_state == 0) begin
                if (p >= 0) begin
                    m_exp = next_code(q); m_run = 1;
                    m_state = (LC == 1) ? 2 : 1;
                end
            end else if (m_state == 1) begin
                if (q == m_exp) begin
                    m_run++; m_exp = next_code(q);
                    if (m_run >= LC) m_state = 2;
                end else if (p >= 0) begin
                    m_run = 1; m_exp = next_code(q);
                end else begin
                    m_state = 0; m_run = 0; m_exp = 0;
                end
            end else begin
                if (q == m_exp) begin
                    m_miss = 0; m_exp = next_code(q);
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_miss++;
                    if (m_miss >= EL) begin
                        m_state = 0; m_exp = 0; m_miss = 0; m_run = 0;
                    end else begin
                        m_exp = next_code(m_exp);
                    end
                end
            end
        end
        if (c) m_cnt = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".idx"},      int'(bus.idx),      m_idx);
        check({tag, ".expected"}, int'(bus.expected), m_exp);
        check({tag, ".locked"},   int'(bus.locked),   (m_state == 2) ? 1 : 0);
        check({tag, ".err"},      int'(bus.err),      m_err);
        check({tag, ".err_cnt"},  int'(bus.err_cnt),  m_cnt);
`ifdef SEQ_CHK_ILLEGAL_DETECT_EN
        check({tag, ".illegal"},  int'(bus.illegal),  m_ill);
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit v, input int q, input bit c);
        bus.q_valid = v;
        bus.q_in    = 3'(q);
        bus.clr_cnt = c;
        @(posedge clk);
        model_step(v, q, c);
        #1;
    endtask

    typedef struct {
        int v, q, c;
        int e_idx, e_exp, e_lock, e_err, e_cnt, e_ill;
    } vec_t;

    vec_t vec[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{1, 0, 0,  0, 1, 0, 0, 0, 0};
        vec[1]  = '{1, 1, 0,  1, 3, 0, 0, 0, 0};
        vec[2]  = '{1, 3, 0,  2, 7, 1, 0, 0, 0};
        vec[3]  = '{1, 7, 0,  3, 2, 1, 0, 0, 0};
        vec[4]  = '{1, 2, 0,  4, 0, 1, 0, 0, 0};
        vec[5]  = '{1, 0, 0,  0, 1, 1, 0, 0, 0};
        vec[6]  = '{1, 1, 0,  1, 3, 1, 0, 0, 0};
        vec[7]  = '{1, 3, 0,  2, 7, 1, 0, 0, 0};
        vec[8]  = '{1, 3, 0,  2, 2, 1, 1, 1, 0};
        vec[9]  = '{1, 2, 0,  4, 0, 1, 0, 1, 0};
        vec[10] = '{1, 1, 0,  1, 1, 1, 1, 2, 0};
        vec[11] = '{1, 3, 0,  2, 0, 0, 1, 3, 0};
        vec[12] = '{1, 0, 0,  0, 1, 0, 0, 3, 0};
        vec[13] = '{1, 5, 0,  0, 0, 0, 0, 3, 1};
        vec[14] = '{0, 5, 0,  0, 0, 0, 0, 3, 0};
        vec[15] = '{1, 4, 0,  0, 0, 0, 0, 3, 1};

        bus.q_valid = 1'b0;
        bus.q_in    = 3'd0;
        bus.clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vec[i].v[0], vec[i].q, vec[i].c[0]);
            check($sformatf("vec%0d.idx", i),      int'(bus.idx),      vec[i].e_idx);
            check($sformatf("vec%0d.expected", i), int'(bus.expected), vec[i].e_exp);
            check($sformatf("vec%0d.locked", i),   int'(bus.locked),   vec[i].e_lock);
            check($sformatf("vec%0d.err", i),      int'(bus.err),      vec[i].e_err);
            check($sformatf("vec%0d.err_cnt", i),  int'(bus.err_cnt),  vec[i].e_cnt);
`ifdef SEQ_CHK_ILLEGAL_DETECT_EN
            check($sformatf("vec%0d.illegal", i),  int'(bus.illegal),  vec[i].e_ill);
`endif
            check_all($sformatf("vec%0d.model", i));
        end

        // Saturation: 300 isolated misses, each recovered by the flywheel-expected code.
        step(1, 0, 0); step(1, 1, 0); step(1, 3, 0);
        check("sat.locked", int'(bus.locked), 1);
        for (int i = 0; i < 300; i++) begin
            step(1, 4, 0);
            check_all("sat.miss");
            step(1, m_exp, 0);
            check_all("sat.hit");
        end
        check("sat.err_cnt", int'(bus.err_cnt), 255);
        check("sat.locked_after", int'(bus.locked), 1);
        step(1, 4, 1);
        check("clr_wins.err_cnt", int'(bus.err_cnt), 0);
        check("clr_wins.err", int'(bus.err), 1);
        step(1, m_exp, 0);
        check_all("clr_wins.recover");

        // q_valid toggling while locked: invalid cycles change nothing but err.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(1, m_exp, 0);
            else            step(0, $urandom_range(0, 7), 0);
            check_all("toggle");
        end
        step(1, 6, 0);
        step(0, 6, 0);
        check("toggle.err_drop", int'(bus.err), 0);
        check_all("toggle.hold");

        // Asynchronous reset in the middle of a cycle.
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        step(1, 0, 0); step(1, 1, 0);
        check("relock.wait", int'(bus.locked), 0);
        step(1, 3, 0);
        check("relock.done", int'(bus.locked), 1);
        check_all("relock");

        // Random run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit v, c;
            int q;
            v = ($urandom_range(0, 3) != 0);
            q = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 7));
            c = v && ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 600) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_all("rand.rst");
                @(posedge clk);
                #1 rst = 1'b1;
            end
            step(v, q, c);
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
